// File: rtl/adc_fft_frame_if.sv
// ADC -> RAM -> FFT bus bundle for the ping-pong frame controller.
// master = controller side, slave = ADC front end / RAM / FFT side.
interface adc_fft_frame_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              ram_cea;
    logic [ADDR_W-1:0] ram_ada;
    logic [DATA_W-1:0] ram_din;
    logic              ram_ceb;
    logic [ADDR_W-1:0] ram_adb;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] fft_tdata;
    logic              fft_tvalid;
    logic              fft_tready;
    logic              fft_tlast;

    modport master (
        input  adc_data, adc_valid, ram_dout, fft_tready,
        output ram_cea, ram_ada, ram_din, ram_ceb, ram_adb,
               fft_tdata, fft_tvalid, fft_tlast
    );

    modport slave (
        output adc_data, adc_valid, ram_dout, fft_tready,
        input  ram_cea, ram_ada, ram_din, ram_ceb, ram_adb,
               fft_tdata, fft_tvalid, fft_tlast
    );
endinterface

// File: rtl/adc_fft_frame_ctrl.sv
// Ping-pong frame controller: ADC samples fill one RAM bank while the other
// streams to the FFT through a 2-entry queue that hides the RAM read latency.
module adc_fft_frame_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 2048
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic cont,
    output logic busy,
    output logic overflow,
    adc_fft_frame_if.master bus
);
    localparam int OFS_W = ADDR_W - 1;
    localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_e;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} wr_st_e;
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_DRAIN} rd_st_e;

    bank_e             bank_q [2], bank_d [2];
    wr_st_e            wr_st_q, wr_st_d;
    rd_st_e            rd_st_q, rd_st_d;
    logic              wbank_q, wbank_d, rbank_q, rbank_d;
    logic [OFS_W-1:0]  wofs_q, wofs_d, rofs_q, rofs_d;
    logic              ovf_q, ovf_d;
    logic              smp_vld_q;
    logic [DATA_W-1:0] smp_data_q;
    logic              iss_q, iss_d, iss_last_q, iss_last_d;
    logic [DATA_W-1:0] qd_q [2], qd_d [2];
    logic              ql_q [2], ql_d [2];
    logic              qhead_q, qhead_d;
    logic [1:0]        qcnt_q, qcnt_d;

    logic       wr_en, pop, issue, tvalid;
    logic [2:0] occ;

    assign tvalid = (qcnt_q != 2'd0);
    assign pop    = tvalid & bus.fft_tready;
    // Occupancy the queue will have once this cycle's in-flight read lands.
    assign occ    = {1'b0, qcnt_q} + {2'b0, iss_q} - {2'b0, pop};
    assign issue  = (rd_st_q == R_STREAM) && (occ < 3'd2);
    assign wr_en  = (wr_st_q == W_FILL) && smp_vld_q && !start;

    always_comb begin
        bank_d     = bank_q;
        wr_st_d    = wr_st_q;
        rd_st_d    = rd_st_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        wofs_d     = wofs_q;
        rofs_d     = rofs_q;
        ovf_d      = ovf_q;
        iss_d      = issue;
        iss_last_d = issue && (rofs_q == LAST_OFS);
        qd_d       = qd_q;
        ql_d       = ql_q;
        qhead_d    = qhead_q;
        qcnt_d     = qcnt_q;

        if (start) ovf_d = 1'b0;

        case (wr_st_q)
            W_IDLE: if (start) begin
                if (bank_q[wbank_q] == B_EMPTY) begin
                    wr_st_d         = W_FILL;
                    bank_d[wbank_q] = B_FILLING;
                end else begin
                    wr_st_d = W_WAIT;
                end
            end
            W_FILL: if (start) begin
                wofs_d = '0;
            end else if (smp_vld_q) begin
                if (wofs_q == LAST_OFS) begin
                    bank_d[wbank_q] = B_FULL;
                    wofs_d          = '0;
                    wbank_d         = ~wbank_q;
                    if (!cont) begin
                        wr_st_d = W_IDLE;
                    end else if (bank_q[~wbank_q] == B_EMPTY) begin
                        bank_d[~wbank_q] = B_FILLING;
                    end else begin
                        wr_st_d = W_WAIT;
                    end
                end else begin
                    wofs_d = wofs_q + OFS_W'(1);
                end
            end
            W_WAIT: begin
                if (smp_vld_q && !start) ovf_d = 1'b1;
                if (bank_q[wbank_q] == B_EMPTY) begin
                    wr_st_d         = W_FILL;
                    bank_d[wbank_q] = B_FILLING;
                end
            end
            default: wr_st_d = W_IDLE;
        endcase

        // Reader only ever touches the bank the writer is not on, so its
        // updates to bank_d cannot collide with the writer's above.
        case (rd_st_q)
            R_IDLE: if (bank_q[rbank_q] == B_FULL) begin
                rd_st_d         = R_STREAM;
                bank_d[rbank_q] = B_READING;
                rofs_d          = '0;
            end
            R_STREAM: if (issue) begin
                rofs_d = rofs_q + OFS_W'(1);
                if (rofs_q == LAST_OFS) rd_st_d = R_DRAIN;
            end
            R_DRAIN: if (pop && ql_q[qhead_q]) begin
                bank_d[rbank_q] = B_EMPTY;
                rbank_d         = ~rbank_q;
                rd_st_d         = R_IDLE;
            end
            default: rd_st_d = R_IDLE;
        endcase

        // Write slot is computed from the pre-pop head; full+push implies pop.
        if (iss_q) begin
            qd_d[qhead_q ^ qcnt_q[0]] = bus.ram_dout;
            ql_d[qhead_q ^ qcnt_q[0]] = iss_last_q;
        end
        if (pop) qhead_d = ~qhead_q;
        case ({iss_q, pop})
            2'b10:   qcnt_d = qcnt_q + 2'd1;
            2'b01:   qcnt_d = qcnt_q - 2'd1;
            default: qcnt_d = qcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q     <= '{B_EMPTY, B_EMPTY};
            wr_st_q    <= W_IDLE;
            rd_st_q    <= R_IDLE;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wofs_q     <= '0;
            rofs_q     <= '0;
            ovf_q      <= 1'b0;
            smp_vld_q  <= 1'b0;
            smp_data_q <= '0;
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            qd_q       <= '{default: '0};
            ql_q       <= '{default: 1'b0};
            qhead_q    <= 1'b0;
            qcnt_q     <= 2'd0;
        end else begin
            bank_q     <= bank_d;
            wr_st_q    <= wr_st_d;
            rd_st_q    <= rd_st_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            wofs_q     <= wofs_d;
            rofs_q     <= rofs_d;
            ovf_q      <= ovf_d;
            smp_vld_q  <= bus.adc_valid;
            smp_data_q <= bus.adc_data;
            iss_q      <= iss_d;
            iss_last_q <= iss_last_d;
            qd_q       <= qd_d;
            ql_q       <= ql_d;
            qhead_q    <= qhead_d;
            qcnt_q     <= qcnt_d;
        end
    end

    assign bus.ram_cea    = wr_en;
    assign bus.ram_ada    = wr_en ? {wbank_q, wofs_q} : '0;
    assign bus.ram_din    = wr_en ? smp_data_q : '0;
    assign bus.ram_ceb    = issue;
    assign bus.ram_adb    = issue ? {rbank_q, rofs_q} : '0;
    assign bus.fft_tvalid = tvalid;
    assign bus.fft_tdata  = qd_q[qhead_q];
    assign bus.fft_tlast  = tvalid & ql_q[qhead_q];

    assign busy     = (wr_st_q != W_IDLE) || (rd_st_q != R_IDLE) ||
                      (bank_q[0] == B_FULL) || (bank_q[1] == B_FULL);
    assign overflow = ovf_q;
endmodule

// File: tb/tb_adc_fft_frame_ctrl.sv
// Bench for adc_fft_frame_ctrl: RAM model, frame-level scoreboard of expected
// RAM writes and FFT beats, and directed scenarios with literal spot checks.
module tb_adc_fft_frame_ctrl;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int FL = 8;
    localparam int HALF = 1 << (AW - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic busy, overflow;

    adc_fft_frame_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    adc_fft_frame_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .busy(busy), .overflow(overflow), .bus(bus)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM, one-cycle read latency.
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rdout = '0;
    assign bus.ram_dout = rdout;
    always @(posedge clk) begin
        if (bus.ram_cea) mem[bus.ram_ada] <= bus.ram_din;
        if (bus.ram_ceb) rdout <= mem[bus.ram_adb];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail1(input string nm, input longint act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d with nothing expected", nm, act);
    endtask

    // Frame-level model: complete frames alternate banks and reach the FFT in
    // the order they were written; partial frames only produce RAM writes.
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    typedef struct packed {logic [DW-1:0] d; logic l;} ax_t;
    wr_t exp_wr[$];
    ax_t exp_ax[$];
    int  wb = 0;

    task automatic model_partial(input int base, input int n);
        for (int i = 0; i < n; i++)
            exp_wr.push_back('{a: AW'(wb * HALF + i), d: DW'(base + i)});
    endtask

    task automatic model_frame(input int base);
        model_partial(base, FL);
        for (int i = 0; i < FL; i++)
            exp_ax.push_back('{d: DW'(base + i), l: (i == FL - 1)});
        wb = 1 - wb;
    endtask

    // Monitor: every write and every accepted beat is checked against the model.
    int cyc = 0, tv_cnt = 0, n_stall = 0;
    int t_ceb = -1, t_tv = -1, t_acc0 = -1, t_accl = -1;
    bit lat_arm = 0;
    bit stall_p = 0;
    logic [DW-1:0] pd;
    logic pl;
    always @(negedge clk) begin : mon
        wr_t w;
        ax_t x;
        cyc++;
        if (!rst_n) begin
            stall_p = 0;
        end else begin
            if (bus.ram_cea) begin
                if (exp_wr.size() == 0) fail1("wr_unexpected", bus.ram_ada);
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus.ram_ada, w.a);
                    chk("wr_data", bus.ram_din, w.d);
                end
            end
            if (stall_p) begin
                n_stall++;
                chk("stall_valid", bus.fft_tvalid, 1);
                chk("stall_data", {bus.fft_tdata, bus.fft_tlast}, {pd, pl});
            end
            if (bus.fft_tvalid && bus.fft_tready) begin
                if (exp_ax.size() == 0) fail1("fft_unexpected", bus.fft_tdata);
                else begin
                    x = exp_ax.pop_front();
                    chk("fft_data", bus.fft_tdata, x.d);
                    chk("fft_last", bus.fft_tlast, x.l);
                end
                if (lat_arm) begin
                    if (t_acc0 < 0) t_acc0 = cyc;
                    t_accl = cyc;
                end
            end
            if (lat_arm && bus.ram_ceb && t_ceb < 0) t_ceb = cyc;
            if (lat_arm && bus.fft_tvalid && t_tv < 0) t_tv = cyc;
            if (bus.fft_tvalid) tv_cnt++;
            stall_p = bus.fft_tvalid && !bus.fft_tready;
            pd = bus.fft_tdata;
            pl = bus.fft_tlast;
        end
    end

    bit tog = 0;
    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) bus.fft_tready = ~bus.fft_tready;
    endtask

    task automatic send(input int base, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = DW'(base + i);
            tick();
            if (gap) begin
                bus.adc_valid = 1'b0;
                tick();
            end
        end
        bus.adc_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while ((exp_wr.size() + exp_ax.size()) != 0 && k < 600) begin
            tick();
            k++;
        end
        chk(nm, exp_wr.size() + exp_ax.size(), 0);
        repeat (3) tick();
    endtask

    function automatic longint outs();
        return longint'({bus.ram_cea, bus.ram_ada, bus.ram_din, bus.ram_ceb,
                         bus.ram_adb, bus.fft_tdata, bus.fft_tvalid,
                         bus.fft_tlast, busy, overflow});
    endfunction

    initial begin
        bus.adc_valid  = 1'b0;
        bus.adc_data   = '0;
        bus.fft_tready = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("reset_outs", outs(), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single-shot frames: ramp to bank 0, then a second frame to bank 1.
        lat_arm = 1;
        model_frame(0);
        pulse_start();
        send(0, FL, 0);
        wait_drain("t1_frame0");
        lat_arm = 0;
        chk("t1_first_tvalid_lat", t_tv - t_ceb, 2);
        chk("t1_rate", t_accl - t_acc0, FL - 1);
        chk("t1_mem0", mem[5], 5);
        model_frame(10);
        pulse_start();
        send(10, FL, 0);
        wait_drain("t1_frame1");
        chk("t1_mem1", mem[HALF + 3], 13);
        chk("t1_busy", busy, 0);

        // Back-pressure toggling each cycle.
        tog = 1;
        model_frame(20);
        pulse_start();
        send(20, FL, 0);
        wait_drain("t2_drain");
        tog = 0;
        bus.fft_tready = 1'b1;
        chk("t2_stalled", n_stall > 0, 1);

        // Both banks fill while FFT is stalled; third frame is dropped.
        cont = 1'b1;
        bus.fft_tready = 1'b0;
        model_frame(30);
        model_frame(38);
        pulse_start();
        send(30, 3 * FL, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_busy", busy, 1);
        chk("t3_head", bus.fft_tdata, 30);
        chk("t3_held", exp_ax.size(), 2 * FL);
        bus.fft_tready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_sticky", overflow, 1);
        chk("t3_writer_busy", busy, 1);

        // Restart mid-frame: partial writes discarded, overflow cleared.
        cont = 1'b0;
        model_partial(60, 5);
        send(60, 5, 0);
        pulse_start();
        chk("t6_ovf_clear", overflow, 0);
        model_frame(70);
        send(70, FL, 0);
        wait_drain("t6_drain");
        chk("t6_busy", busy, 0);

        // Continuous capture over 10 frames at half rate.
        cont = 1'b1;
        for (int f = 0; f < 10; f++) model_frame(100 + f * FL);
        pulse_start();
        send(100, 10 * FL, 1);
        wait_drain("t4_drain");
        chk("t4_no_overflow", overflow, 0);

        // Asynchronous reset in the middle of a frame.
        model_partial(200, 4);
        send(200, 4, 0);
        bus.adc_valid = 1'b1;
        bus.adc_data  = 8'd204;
        rst_n = 1'b0;
        #1 chk("t5_reset_outs", outs(), 0);
        chk("t5_model_empty", exp_wr.size() + exp_ax.size(), 0);
        wb = 0;
        bus.adc_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tv_cnt = 0;
        send(210, 20, 0);
        chk("t5_no_tvalid", tv_cnt, 0);
        chk("t5_idle", busy, 0);
        cont = 1'b0;
        model_frame(220);
        pulse_start();
        send(220, FL, 0);
        wait_drain("t5_recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
